mp_add_sequencer: RTL and testbench

MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

---
 rtl/mp_add_sequencer.sv | 98 +++++++++
 tb/tb_mp_add_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mp_add_sequencer.sv
// Sequences multi-word additions through an external single-cycle adder,
// chaining carry between words and registering one result beat per accepted operand beat.
module mp_add_sequencer #(
    parameter int N         = 64,
    parameter int MAX_WORDS = 4,
    localparam int W        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_first,
    input  logic         in_last,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_cout,
    output logic         out_zero,
    output logic         out_err
);

    typedef enum logic {IDLE, CHAIN} state_t;

    localparam logic [W-1:0] LAST_IDX = W'(MAX_WORDS - 1);

    state_t       state, state_nxt;
    logic         carry_q;
    logic [W-1:0] idx_q;
    logic         zacc_q;

    logic         accept, starts, forced, eff_last, beat_err, beat_zero;
    logic [W-1:0] beat_idx;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign add_a    = in_a;
    assign add_b    = in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = eff_last ? IDLE : CHAIN;
    end

    // A beat in IDLE always opens a transaction; in_first in CHAIN abandons the open one.
    always_comb begin
        starts    = (state == IDLE) || in_first;
        beat_idx  = starts ? '0 : idx_q;
        forced    = (beat_idx == LAST_IDX) && !in_last;
        eff_last  = in_last || forced;
        beat_err  = ((state == CHAIN) && in_first) || ((state == IDLE) && !in_first) || forced;
        beat_zero = (starts ? 1'b1 : zacc_q) && (add_sum == '0);
        add_cin   = starts ? in_cin : carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            zacc_q    <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_idx   <= beat_idx;
            out_last  <= eff_last;
            out_cout  <= add_cout;
            out_zero  <= beat_zero;
            out_err   <= beat_err;
            carry_q   <= add_cout;
            idx_q     <= beat_idx + W'(1);
            zacc_q    <= beat_zero;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed and random checks of mp_add_sequencer against a wide-integer model of
// each transaction, with the downstream adder modelled as plain arithmetic.
module tb_mp_add_sequencer;
    localparam int N  = 64;
    localparam int MW = 4;
    localparam int T  = N * MW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_cin, in_first, in_last;
    logic [N-1:0]  in_a, in_b, add_a, add_b, add_sum, out_sum;
    logic          add_cin, add_cout;
    logic          out_valid, out_ready, out_last, out_cout, out_zero, out_err;
    logic [1:0]    out_idx;

    mp_add_sequencer #(.N(N), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .in_first(in_first), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
        .out_cout(out_cout), .out_zero(out_zero), .out_err(out_err)
    );

    assign {add_cout, add_sum} = 65'(add_a) + 65'(add_b) + 65'(add_cin);

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: the open transaction as two wide integers plus its carry-in.
    logic          open, cin0, pcarry;
    int            cnt;
    logic [T-1:0]  A, B;
    logic          ev, elast, ecout, ezero, eerr;
    logic [N-1:0]  esum;
    int            eidx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        open = 1'b0; cnt = 0; A = '0; B = '0; cin0 = 1'b0; pcarry = 1'b0;
        ev = 1'b0; esum = '0; eidx = 0; elast = 1'b0; ecout = 1'b0; ezero = 1'b0; eerr = 1'b0;
    endtask

    task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic f, input logic l, input logic r);
        logic rdy, st, ecin, forced;
        int k;
        logic [T-1:0] tot, mask;
        in_valid = v; in_a = a; in_b = b; in_cin = cin;
        in_first = f; in_last = l; out_ready = r;
        #1;
        rdy  = !ev || r;
        st   = !open || f;
        ecin = st ? cin : pcarry;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("add_cin", 64'(add_cin), 64'(ecin));
        chk("add_a", add_a, a);
        if (v && rdy) begin
            k = st ? 0 : cnt;
            if (st) begin A = '0; B = '0; cin0 = cin; end
            forced = (k == MW - 1) && !l;
            A = A | (T'(a) << (k * N));
            B = B | (T'(b) << (k * N));
            tot  = A + B + T'(cin0);
            mask = (T'(1) << ((k + 1) * N)) - T'(1);
            ev    = 1'b1;
            esum  = tot[k*N +: N];
            ecout = tot[(k + 1) * N];
            ezero = ((tot & mask) == '0);
            eidx  = k;
            elast = l || forced;
            eerr  = (open && f) || (!open && !f) || forced;
            pcarry = ecout;
            open   = !elast;
            cnt    = k + 1;
        end else if (r) begin
            ev = 1'b0;
        end
        @(posedge clk); #1;
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            chk("out_sum", out_sum, esum);
            chk("out_idx", 64'(out_idx), 64'(eidx));
            chk("out_last", 64'(out_last), 64'(elast));
            chk("out_err", 64'(out_err), 64'(eerr));
            if (elast) begin
                chk("out_cout", 64'(out_cout), 64'(ecout));
                chk("out_zero", 64'(out_zero), 64'(ezero));
            end
        end
        @(negedge clk);
    endtask

    // Asserted away from any clock edge so the asynchronous path is what gets checked.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_flags", {58'd0, out_last, out_cout, out_zero, out_err, 2'b00}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    localparam logic [N-1:0] ONES = '1;

    initial begin
        in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_first = 0; in_last = 0; out_ready = 1;
        model_reset();
        rst_n = 1'b0;
        #2;
        apply_reset();

        // single beat wrapping to zero with carry out
        step(1, ONES, 64'd1, 0, 1, 1, 1);
        chk("single_sum", out_sum, 64'd0);
        chk("single_cout", 64'(out_cout), 64'd1);
        chk("single_zero", 64'(out_zero), 64'd1);

        // two-word add propagating carry into the upper word
        step(1, ONES, 64'd1, 0, 1, 0, 1);
        step(1, 64'd0, 64'd0, 0, 0, 1, 1);
        chk("two_word_hi", out_sum, 64'd1);
        chk("two_word_idx", 64'(out_idx), 64'd1);

        // backpressure with a beat held on the input
        step(1, 64'd5, 64'd6, 0, 1, 0, 1);
        step(1, 64'd7, 64'd8, 0, 0, 1, 0);
        step(1, 64'd7, 64'd8, 0, 0, 1, 0);
        step(1, 64'd7, 64'd8, 0, 0, 1, 0);
        step(1, 64'd7, 64'd8, 0, 0, 1, 1);
        chk("bp_resume_sum", out_sum, 64'd15);
        step(0, 64'd0, 64'd0, 0, 0, 0, 1);

        // word-count overflow, then a fresh transaction using in_cin
        step(1, 64'd1, 64'd1, 0, 1, 0, 1);
        step(1, ONES, 64'd1, 0, 0, 0, 1);
        step(1, 64'd2, 64'd2, 0, 0, 0, 1);
        step(1, 64'd3, 64'd3, 0, 0, 0, 1);
        chk("ovf_idx", 64'(out_idx), 64'd3);
        chk("ovf_err", 64'(out_err), 64'd1);
        step(1, 64'd4, 64'd4, 1, 0, 1, 1);
        chk("ovf_next_idx", 64'(out_idx), 64'd0);
        chk("ovf_next_sum", out_sum, 64'd9);

        // restart mid-transaction while carry_q = 1
        step(1, ONES, 64'd1, 0, 1, 0, 1);
        step(1, 64'd10, 64'd20, 0, 1, 1, 1);
        chk("restart_err", 64'(out_err), 64'd1);
        chk("restart_sum", out_sum, 64'd30);

        // reset mid-CHAIN
        step(1, ONES, 64'd1, 0, 1, 0, 1);
        apply_reset();
        step(1, 64'd100, 64'd1, 1, 1, 1, 1);
        chk("post_rst_sum", out_sum, 64'd102);

        for (int i = 0; i < 400; i++) begin
            logic v, f, l, r;
            v = ($urandom_range(0, 3) != 0);
            f = open ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 7) != 0);
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
            step(v, pick(), pick(), 1'($urandom_range(0, 1)), f, l, r);
            if (i == 200) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
